pulpino_boot_ctrl: RTL and testbench

PULPINO_BOOT_CTRL -- requirements
Module: pulpino_boot_ctrl

---
 rtl/pulpino_boot_pkg.sv | 50 +++++
 rtl/pulpino_sat_cnt.sv | 34 +++
 rtl/pulpino_boot_ctrl.sv | 110 +++++++++++
 tb/tb_pulpino_boot_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulpino_boot_pkg.sv
// Shared types and constants for the PULPino boot controller.
package pulpino_boot_pkg;

  localparam int unsigned BOOT_RST_CYCLES_DEFAULT = 16;
  localparam int unsigned BOOT_CNT_W_DEFAULT      = 32;
  localparam int unsigned HOLD_CNT_W              = 8;

  typedef enum logic [2:0] {
    BOOT_IDLE = 3'd0,
    BOOT_HOLD = 3'd1,
    BOOT_LOAD = 3'd2,
    BOOT_RUN  = 3'd3,
    BOOT_DONE = 3'd4,
    BOOT_TOUT = 3'd5
  } boot_state_e;

  typedef struct packed {
    logic core_rst_n;
    logic fetch_en;
    logic busy;
    logic done;
    logic tout;
  } boot_out_t;

  // Output pattern for a state; registered against the next state so flops track the FSM.
  function automatic boot_out_t boot_decode(input boot_state_e st);
    boot_out_t o;
    o = '0;
    case (st)
      BOOT_HOLD: o.busy = 1'b1;
      BOOT_LOAD: begin
        o.core_rst_n = 1'b1;
        o.busy       = 1'b1;
      end
      BOOT_RUN: begin
        o.core_rst_n = 1'b1;
        o.fetch_en   = 1'b1;
        o.busy       = 1'b1;
      end
      BOOT_DONE: begin
        o.core_rst_n = 1'b1;
        o.done       = 1'b1;
      end
      BOOT_TOUT: o.tout = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pulpino_sat_cnt.sv
// Clearable, enabled up-counter that sticks at all-ones.
module pulpino_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pulpino_boot_ctrl.sv
// Boot sequencer: holds the SoC in reset, waits for the SPI loader, runs the core until EOC.
// Optional watchdog (RUN -> TOUT) is built only when PULPINO_BOOT_WDOG_EN is defined.
module pulpino_boot_ctrl
  import pulpino_boot_pkg::*;
#(
  parameter int unsigned RST_CYCLES = BOOT_RST_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = BOOT_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             load_done_i,
  input  logic             eoc_i,
  input  logic [CNT_W-1:0] timeout_lim_i,
  output logic             core_rst_n_o,
  output logic             fetch_enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] run_cycles_o
);

  boot_state_e          state_q;
  boot_state_e          state_d;
  boot_out_t            out_q;
  boot_out_t            out_d;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0]      run_cnt;
  logic                  hold_last_c;
  logic                  wdog_fire_c;
  logic                  run_clr_c;

  assign hold_last_c = (hold_cnt == HOLD_CNT_W'(RST_CYCLES - 1));

`ifdef PULPINO_BOOT_WDOG_EN
  // run_cnt counts completed RUN cycles, so limit-1 here means the N-th edge leaves RUN.
  assign wdog_fire_c = (timeout_lim_i != '0) && (run_cnt >= (timeout_lim_i - CNT_W'(1)));
`else
  logic unused_timeout_lim;
  assign unused_timeout_lim = ^timeout_lim_i;
  assign wdog_fire_c        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT_IDLE: if (start_i) state_d = BOOT_HOLD;
      BOOT_HOLD: if (hold_last_c) state_d = BOOT_LOAD;
      BOOT_LOAD: if (load_done_i) state_d = BOOT_RUN;
      BOOT_RUN: begin
        if (eoc_i) begin
          state_d = BOOT_DONE;
        end else if (wdog_fire_c) begin
          state_d = BOOT_TOUT;
        end
      end
      BOOT_DONE, BOOT_TOUT: if (start_i) state_d = BOOT_HOLD;
      default: state_d = BOOT_IDLE;
    endcase
    if (abort_i) begin
      state_d = BOOT_IDLE;
    end
    out_d = boot_decode(state_d);
`ifndef PULPINO_BOOT_WDOG_EN
    out_d.tout = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  pulpino_sat_cnt #(
    .CNT_W (HOLD_CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != BOOT_HOLD),
    .en_i  (state_q == BOOT_HOLD),
    .cnt_o (hold_cnt)
  );

  // Run counter is zeroed on every (re)start and on abort, and otherwise holds outside RUN.
  assign run_clr_c = (state_d == BOOT_IDLE) || (state_d == BOOT_HOLD);

  pulpino_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (run_clr_c),
    .en_i  (state_q == BOOT_RUN),
    .cnt_o (run_cnt)
  );

  assign core_rst_n_o   = out_q.core_rst_n;
  assign fetch_enable_o = out_q.fetch_en;
  assign busy_o         = out_q.busy;
  assign done_o         = out_q.done;
  assign timeout_o      = out_q.tout;
  assign run_cycles_o   = run_cnt;

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Self-checking bench for pulpino_boot_ctrl; expected values queued at stimulus time.
`timescale 1ns/1ps
module tb_pulpino_boot_ctrl;

  localparam int unsigned CNT_W = 32;
  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_HOLD = 5'b00100;
  localparam logic [4:0] ST_LOAD = 5'b10100;
  localparam logic [4:0] ST_RUN  = 5'b11100;
  localparam logic [4:0] ST_DONE = 5'b10010;
  localparam logic [4:0] ST_TOUT = 5'b00001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic             abort_i;
  logic             load_done_i;
  logic             eoc_i;
  logic [CNT_W-1:0] timeout_lim_i;
  logic             core_rst_n_o;
  logic             fetch_enable_o;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] run_cycles_o;
  logic [4:0]       st;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];
  longint exp_v;

  assign st = {core_rst_n_o, fetch_enable_o, busy_o, done_o, timeout_o};

  always #5 clk = ~clk;

  pulpino_boot_ctrl #(
    .RST_CYCLES (16),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .load_done_i    (load_done_i),
    .eoc_i          (eoc_i),
    .timeout_lim_i  (timeout_lim_i),
    .core_rst_n_o   (core_rst_n_o),
    .fetch_enable_o (fetch_enable_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .run_cycles_o   (run_cycles_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic measure_hold(input int n0, output int n);
    n = n0;
    while (core_rst_n_o === 1'b0 && busy_o === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic enter_run();
    load_done_i = 1'b1;
    tick();
    load_done_i = 1'b0;
  endtask

  task automatic run_loop(input int eoc_at, input int limit, output int n);
    n = 0;
    while (fetch_enable_o === 1'b1 && n < limit) begin
      eoc_i = (n == eoc_at);
      n++;
      tick();
    end
    eoc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; load_done_i = 1'b0; eoc_i = 1'b0;
    timeout_lim_i = '0;
    #3;
    n_checks++;
    if (st !== ST_IDLE || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_IDLE);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (st !== ST_IDLE || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_IDLE);
    end
  endtask

  task automatic test_boot_done();
    int n;
    int bad;
    exp_q.push_back(16);
    pulse_start();
    n_checks++;
    if (st !== ST_HOLD) begin
      n_fail++;
      $display("FAIL hold_entry: got st=%b expected %b", st, ST_HOLD);
    end
    measure_hold(0, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v) begin
      n_fail++;
      $display("FAIL hold_len: got %0d expected %0d", n, exp_v);
    end
    repeat (3) tick();
    n_checks++;
    if (st !== ST_LOAD) begin
      n_fail++;
      $display("FAIL load_wait: got st=%b expected %b", st, ST_LOAD);
    end
    exp_q.push_back(100);
    enter_run();
    n_checks++;
    if (st !== ST_RUN || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL run_entry: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_RUN);
    end
    n = 0;
    bad = 0;
    while (fetch_enable_o === 1'b1 && n < 300) begin
      if (run_cycles_o !== CNT_W'(n)) bad++;
      eoc_i = (n == 99);
      n++;
      tick();
    end
    eoc_i = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL run_count_track: got %0d mismatching cycles expected 0", bad);
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v || run_cycles_o !== CNT_W'(exp_v)) begin
      n_fail++;
      $display("FAIL run_len: got fetch=%0d run=%0d expected %0d", n, run_cycles_o, exp_v);
    end
    n_checks++;
    if (st !== ST_DONE) begin
      n_fail++;
      $display("FAIL done_state: got st=%b expected %b", st, ST_DONE);
    end
    repeat (5) tick();
    n_checks++;
    if (st !== ST_DONE || run_cycles_o !== CNT_W'(100)) begin
      n_fail++;
      $display("FAIL done_sticky: got st=%b run=%0d expected st=%b run=100", st, run_cycles_o, ST_DONE);
    end
  endtask

  task automatic test_restart_and_ignore();
    int n;
    pulse_start();
    n_checks++;
    if (st !== ST_HOLD || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL restart_clear: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_HOLD);
    end
    repeat (4) tick();
    exp_q.push_back(16);
    pulse_start();
    measure_hold(5, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v) begin
      n_fail++;
      $display("FAIL hold_len_start_in_hold: got %0d expected %0d", n, exp_v);
    end
    pulse_start();
    n_checks++;
    if (st !== ST_LOAD) begin
      n_fail++;
      $display("FAIL start_in_load: got st=%b expected %b", st, ST_LOAD);
    end
    enter_run();
    repeat (10) tick();
    pulse_start();
    n_checks++;
    if (st !== ST_RUN || run_cycles_o !== CNT_W'(11)) begin
      n_fail++;
      $display("FAIL start_in_run: got st=%b run=%0d expected st=%b run=11", st, run_cycles_o, ST_RUN);
    end
  endtask

  task automatic test_abort();
    abort_i = 1'b1; start_i = 1'b1; eoc_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0; eoc_i = 1'b0;
    n_checks++;
    if (st !== ST_IDLE || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL abort_run: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_IDLE);
    end
    repeat (3) tick();
    n_checks++;
    if (st !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_stays_idle: got st=%b expected %b", st, ST_IDLE);
    end
    pulse_start();
    tick(); tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_checks++;
    if (st !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_hold: got st=%b expected %b", st, ST_IDLE);
    end
  endtask

  task automatic test_watchdog();
    int n;
    timeout_lim_i = CNT_W'(50);
    pulse_start();
    measure_hold(0, n);
    enter_run();
`ifdef PULPINO_BOOT_WDOG_EN
    exp_q.push_back(50);
    run_loop(-1, 200, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v || run_cycles_o !== CNT_W'(exp_v)) begin
      n_fail++;
      $display("FAIL wdog_len: got fetch=%0d run=%0d expected %0d", n, run_cycles_o, exp_v);
    end
    n_checks++;
    if (st !== ST_TOUT) begin
      n_fail++;
      $display("FAIL wdog_state: got st=%b expected %b", st, ST_TOUT);
    end
    repeat (3) tick();
    n_checks++;
    if (st !== ST_TOUT) begin
      n_fail++;
      $display("FAIL tout_sticky: got st=%b expected %b", st, ST_TOUT);
    end
    pulse_start();
    n_checks++;
    if (st !== ST_HOLD || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL restart_from_tout: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_HOLD);
    end
`else
    exp_q.push_back(200);
    run_loop(-1, 200, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v || st !== ST_RUN || run_cycles_o !== CNT_W'(exp_v)) begin
      n_fail++;
      $display("FAIL no_wdog_stays_run: got n=%0d st=%b run=%0d expected n=%0d st=%b", n, st, run_cycles_o, exp_v, ST_RUN);
    end
`endif
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  task automatic test_wdog_eoc_tie();
    int n;
    timeout_lim_i = CNT_W'(50);
    pulse_start();
    measure_hold(0, n);
    enter_run();
    exp_q.push_back(50);
    run_loop(49, 200, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v || st !== ST_DONE || run_cycles_o !== CNT_W'(exp_v)) begin
      n_fail++;
      $display("FAIL eoc_beats_wdog: got n=%0d st=%b run=%0d expected n=%0d st=%b", n, st, run_cycles_o, exp_v, ST_DONE);
    end
  endtask

  task automatic test_wdog_off();
    int n;
    timeout_lim_i = '0;
    pulse_start();
    measure_hold(0, n);
    enter_run();
    exp_q.push_back(80);
    run_loop(-1, 80, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v || st !== ST_RUN) begin
      n_fail++;
      $display("FAIL lim_zero_runs: got n=%0d st=%b expected n=%0d st=%b", n, st, exp_v, ST_RUN);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (st !== ST_IDLE || run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%b run=%0d expected st=%b run=0", st, run_cycles_o, ST_IDLE);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (st !== ST_IDLE) begin
      n_fail++;
      $display("FAIL idle_after_mid_reset: got st=%b expected %b", st, ST_IDLE);
    end
    exp_q.push_back(16);
    pulse_start();
    measure_hold(0, n);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (n !== exp_v || st !== ST_LOAD) begin
      n_fail++;
      $display("FAIL hold_after_reset: got n=%0d st=%b expected n=%0d st=%b", n, st, exp_v, ST_LOAD);
    end
  endtask

  initial begin
    test_reset();
    test_boot_done();
    test_restart_and_ignore();
    test_abort();
    test_watchdog();
    test_wdog_eoc_tie();
    test_wdog_off();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
